// File: rtl/sprite_pass_engine.sv
// Erase/redraw sequencer for N_OBJ rectangular sprites on a pixel-write bus.
// Per pass: erase each changed sprite at its last position, then redraw it.
module sprite_pass_engine #(
    parameter int N_OBJ          = 8,
    parameter int XW             = 8,
    parameter int YW             = 7,
    parameter int CW             = 3,
    parameter int SPR_W          = 9,
    parameter int SPR_H          = 9,
    parameter int SCR_W          = 160,
    parameter int SCR_H          = 120,
    parameter int BG_COLOUR      = 0,
    parameter int SKIP_UNCHANGED = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [N_OBJ-1:0]    obj_en,
    input  logic [N_OBJ*XW-1:0] obj_x,
    input  logic [N_OBJ*YW-1:0] obj_y,
    input  logic [N_OBJ*CW-1:0] obj_colour,
    output logic                busy,
    output logic                done,
    output logic [XW-1:0]       pix_x,
    output logic [YW-1:0]       pix_y,
    output logic [CW-1:0]       pix_colour,
    output logic                pix_valid,
    input  logic                pix_ready
);
    localparam int IW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

    typedef enum logic [2:0] {IDLE, SEL, ERASE, DRAW, FIN} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [XW-1:0]       dx_q, dx_d;
    logic [YW-1:0]       dy_q, dy_d;
    logic                loaded_q, loaded_d;
    logic [XW-1:0]       pix_x_q, pix_x_d;
    logic [YW-1:0]       pix_y_q, pix_y_d;
    logic [CW-1:0]       pix_colour_q, pix_colour_d;
    logic                pix_valid_q, pix_valid_d;
    logic [N_OBJ-1:0]    snap_en_q, snap_en_d;
    logic [N_OBJ*XW-1:0] snap_x_q, snap_x_d;
    logic [N_OBJ*YW-1:0] snap_y_q, snap_y_d;
    logic [N_OBJ*CW-1:0] snap_colour_q, snap_colour_d;
    logic [N_OBJ-1:0]    last_vis_q, last_vis_d;
    logic [N_OBJ*XW-1:0] last_x_q, last_x_d;
    logic [N_OBJ*YW-1:0] last_y_q, last_y_d;

    logic          cur_en, cur_lv, unchanged, skip, step, last_dx, last_dy;
    logic [XW-1:0] cur_x, cur_lx, base_x, ldx;
    logic [YW-1:0] cur_y, cur_ly, base_y, ldy;
    logic [CW-1:0] cur_colour, scan_colour;
    logic [XW:0]   abs_x;
    logic [YW:0]   abs_y;
    logic          load, rec_upd, next_obj;

    assign cur_en     = snap_en_q[idx_q];
    assign cur_x      = snap_x_q[idx_q*XW +: XW];
    assign cur_y      = snap_y_q[idx_q*YW +: YW];
    assign cur_colour = snap_colour_q[idx_q*CW +: CW];
    assign cur_lv     = last_vis_q[idx_q];
    assign cur_lx     = last_x_q[idx_q*XW +: XW];
    assign cur_ly     = last_y_q[idx_q*YW +: YW];

    assign unchanged = (cur_en == cur_lv) &&
                       (!cur_en || (cur_x == cur_lx && cur_y == cur_ly));
    assign skip      = (SKIP_UNCHANGED != 0) && unchanged;

    assign base_x      = (state_q == ERASE) ? cur_lx : cur_x;
    assign base_y      = (state_q == ERASE) ? cur_ly : cur_y;
    assign scan_colour = (state_q == ERASE) ? CW'(BG_COLOUR) : cur_colour;
    assign last_dx     = (dx_q == XW'(SPR_W - 1));
    assign last_dy     = (dy_q == YW'(SPR_H - 1));
    // the presented scan position is finished: accepted, or clipped (not valid)
    assign step        = loaded_q && !(pix_valid_q && !pix_ready);
    assign abs_x       = {1'b0, base_x} + {1'b0, ldx};
    assign abs_y       = {1'b0, base_y} + {1'b0, ldy};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            dx_q          <= '0;
            dy_q          <= '0;
            loaded_q      <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_colour_q  <= '0;
            pix_valid_q   <= 1'b0;
            snap_en_q     <= '0;
            snap_x_q      <= '0;
            snap_y_q      <= '0;
            snap_colour_q <= '0;
            last_vis_q    <= '0;
            last_x_q      <= '0;
            last_y_q      <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            dx_q          <= dx_d;
            dy_q          <= dy_d;
            loaded_q      <= loaded_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_colour_q  <= pix_colour_d;
            pix_valid_q   <= pix_valid_d;
            snap_en_q     <= snap_en_d;
            snap_x_q      <= snap_x_d;
            snap_y_q      <= snap_y_d;
            snap_colour_q <= snap_colour_d;
            last_vis_q    <= last_vis_d;
            last_x_q      <= last_x_d;
            last_y_q      <= last_y_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        dx_d          = dx_q;
        dy_d          = dy_q;
        loaded_d      = loaded_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        pix_colour_d  = pix_colour_q;
        pix_valid_d   = pix_valid_q;
        snap_en_d     = snap_en_q;
        snap_x_d      = snap_x_q;
        snap_y_d      = snap_y_q;
        snap_colour_d = snap_colour_q;
        last_vis_d    = last_vis_q;
        last_x_d      = last_x_q;
        last_y_d      = last_y_q;
        load          = 1'b0;
        rec_upd       = 1'b0;
        next_obj      = 1'b0;
        ldx           = '0;
        ldy           = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = SEL;
                    idx_d         = '0;
                    snap_en_d     = obj_en;
                    snap_x_d      = obj_x;
                    snap_y_d      = obj_y;
                    snap_colour_d = obj_colour;
                end
            end
            SEL: begin
                if (skip) begin
                    next_obj = 1'b1;
                end else if (cur_lv) begin
                    state_d = ERASE;
                end else begin
                    rec_upd = 1'b1;
                    if (cur_en) state_d = DRAW;
                    else        next_obj = 1'b1;
                end
            end
            ERASE, DRAW: begin
                if (!loaded_q) begin
                    load = 1'b1;
                end else if (step) begin
                    if (last_dx && last_dy) begin
                        pix_valid_d = 1'b0;
                        loaded_d    = 1'b0;
                        if (state_q == ERASE) begin
                            rec_upd = 1'b1;
                            if (cur_en) state_d = DRAW;
                            else        next_obj = 1'b1;
                        end else begin
                            next_obj = 1'b1;
                        end
                    end else begin
                        load = 1'b1;
                        ldx  = last_dx ? '0 : dx_q + 1'b1;
                        ldy  = last_dx ? dy_q + 1'b1 : dy_q;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (next_obj) begin
            if (idx_q == IW'(N_OBJ - 1)) begin
                state_d = FIN;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = SEL;
            end
        end
        if (rec_upd) begin
            last_vis_d[idx_q]           = cur_en;
            last_x_d[idx_q*XW +: XW]    = cur_x;
            last_y_d[idx_q*YW +: YW]    = cur_y;
        end
        if (load) begin
            dx_d         = ldx;
            dy_d         = ldy;
            loaded_d     = 1'b1;
            pix_x_d      = abs_x[XW-1:0];
            pix_y_d      = abs_y[YW-1:0];
            pix_colour_d = scan_colour;
            pix_valid_d  = (abs_x < (XW+1)'(SCR_W)) && (abs_y < (YW+1)'(SCR_H));
        end
    end

    always_comb begin
        busy       = (state_q != IDLE);
        done       = (state_q == FIN);
        pix_x      = pix_x_q;
        pix_y      = pix_y_q;
        pix_colour = pix_colour_q;
        pix_valid  = pix_valid_q;
    end
endmodule

// File: tb/tb_sprite_pass_engine.sv
// Directed bench for sprite_pass_engine with N_OBJ=2 and 9x9 sprites.
// Expected pixel streams and pass lengths are hand-derived per scenario.
module tb_sprite_pass_engine;
    localparam int N  = 2;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            reset, start, pix_ready;
    logic [N-1:0]    obj_en;
    logic [N*XW-1:0] obj_x;
    logic [N*YW-1:0] obj_y;
    logic [N*CW-1:0] obj_colour;
    logic            busy, done, pix_valid;
    logic [XW-1:0]   pix_x;
    logic [YW-1:0]   pix_y;
    logic [CW-1:0]   pix_colour;

    int checks = 0;
    int errors = 0;
    int gx[$], gy[$], gc[$];
    int ex[$], ey[$], ec[$];
    int sx[5], sy[5], sc[5], sv[5];
    logic done_after, busy_after, busy_first;

    sprite_pass_engine #(
        .N_OBJ(N), .XW(XW), .YW(YW), .CW(CW)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .obj_en(obj_en), .obj_x(obj_x), .obj_y(obj_y),
        .obj_colour(obj_colour),
        .busy(busy), .done(done),
        .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour),
        .pix_valid(pix_valid), .pix_ready(pix_ready)
    );

    always #5 clk = ~clk;

    task automatic set_obj(input int i, input bit en, input int x, input int y, input int c);
        obj_en[i]            = en;
        obj_x[i*XW +: XW]    = x[XW-1:0];
        obj_y[i*YW +: YW]    = y[YW-1:0];
        obj_colour[i*CW +: CW] = c[CW-1:0];
    endtask

    task automatic push_rect(input int x0, input int y0, input int c);
        for (int dy = 0; dy < 9; dy++)
            for (int dx = 0; dx < 9; dx++)
                if (x0 + dx < 160 && y0 + dy < 120) begin
                    ex.push_back(x0 + dx);
                    ey.push_back(y0 + dy);
                    ec.push_back(c);
                end
    endtask

    // Runs one pass; dcyc = negedge index (1 = right after the start edge) where done is seen.
    task automatic run_pass(input int stall_at, input int abort_at, output int dcyc);
        int stall_left;
        bit stalled;
        gx.delete(); gy.delete(); gc.delete();
        dcyc = -1;
        stall_left = 0;
        stalled = 0;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 2000; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 1) busy_first = busy;
            if (stall_at >= 0 && !stalled && gx.size() == stall_at) begin
                stalled = 1;
                stall_left = 5;
            end
            if (stall_left > 0) begin
                pix_ready = 1'b0;
                sx[5-stall_left] = int'(pix_x);
                sy[5-stall_left] = int'(pix_y);
                sc[5-stall_left] = int'(pix_colour);
                sv[5-stall_left] = int'(pix_valid);
                stall_left--;
            end else begin
                pix_ready = 1'b1;
            end
            if (done) begin
                dcyc = n;
                break;
            end
            if (pix_valid && pix_ready) begin
                gx.push_back(int'(pix_x));
                gy.push_back(int'(pix_y));
                gc.push_back(int'(pix_colour));
            end
            if (abort_at >= 0 && gx.size() >= abort_at) begin
                reset = 1'b1;
                return;
            end
        end
        @(negedge clk);
        done_after = done;
        busy_after = busy;
    endtask

    task automatic check_stream(input string name);
        int bad;
        bad = -1;
        checks++;
        if (gx.size() !== ex.size()) begin
            errors++;
            $display("FAIL %s count: got %0d want %0d", name, gx.size(), ex.size());
        end
        checks++;
        for (int i = 0; i < gx.size() && i < ex.size(); i++)
            if (bad < 0 && (gx[i] !== ex[i] || gy[i] !== ey[i] || gc[i] !== ec[i]))
                bad = i;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s pixel %0d: got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                     name, bad, gx[bad], gy[bad], gc[bad], ex[bad], ey[bad], ec[bad]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; pix_ready = 1'b1;
        obj_en = '0; obj_x = '0; obj_y = '0; obj_colour = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, pix_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl: got %b want 000", {busy, done, pix_valid});
        end
        checks++;
        if (pix_x !== '0 || pix_y !== '0 || pix_colour !== '0) begin
            errors++;
            $display("FAIL reset_pix: got (%0d,%0d,%0d) want (0,0,0)", pix_x, pix_y, pix_colour);
        end
    endtask

    task automatic test_first_draw();
        int d;
        set_obj(0, 1, 10, 5, 1);
        set_obj(1, 0, 0, 0, 0);
        ex.delete(); ey.delete(); ec.delete();
        push_rect(10, 5, 1);
        run_pass(-1, -1, d);
        check_stream("first_draw");
        checks++;
        if (d !== 85) begin
            errors++;
            $display("FAIL first_draw_len: got %0d want 85", d);
        end
        checks++;
        if (busy_first !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b want 1", busy_first);
        end
        checks++;
        if (done_after !== 1'b0 || busy_after !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got done=%b busy=%b want 0 0", done_after, busy_after);
        end
    endtask

    task automatic test_move();
        int d;
        set_obj(0, 1, 11, 5, 1);
        ex.delete(); ey.delete(); ec.delete();
        push_rect(10, 5, 0);
        push_rect(11, 5, 1);
        run_pass(-1, -1, d);
        check_stream("move");
        checks++;
        if (d !== 167) begin
            errors++;
            $display("FAIL move_len: got %0d want 167", d);
        end
    endtask

    task automatic test_skip();
        int d;
        ex.delete(); ey.delete(); ec.delete();
        run_pass(-1, -1, d);
        check_stream("skip");
        checks++;
        if (d !== 3) begin
            errors++;
            $display("FAIL skip_len: got %0d want 3", d);
        end
    endtask

    task automatic test_clip();
        int d;
        set_obj(0, 1, 155, 115, 1);
        ex.delete(); ey.delete(); ec.delete();
        push_rect(11, 5, 0);
        push_rect(155, 115, 1);
        run_pass(-1, -1, d);
        check_stream("clip");
        checks++;
        if (d !== 167) begin
            errors++;
            $display("FAIL clip_len: got %0d want 167", d);
        end
    endtask

    task automatic test_backpressure();
        int d;
        set_obj(0, 1, 30, 30, 2);
        ex.delete(); ey.delete(); ec.delete();
        push_rect(155, 115, 0);
        push_rect(30, 30, 2);
        run_pass(65, -1, d);
        check_stream("stall");
        checks++;
        if (d !== 172) begin
            errors++;
            $display("FAIL stall_len: got %0d want 172", d);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (sv[i] !== 1 || sx[i] !== ex[65] || sy[i] !== ey[65] || sc[i] !== ec[65]) begin
                errors++;
                $display("FAIL stall_hold%0d: got v%0d (%0d,%0d,c%0d) want v1 (%0d,%0d,c%0d)",
                         i, sv[i], sx[i], sy[i], sc[i], ex[65], ey[65], ec[65]);
            end
        end
    endtask

    task automatic test_reset_mid_pass();
        int d;
        set_obj(0, 1, 40, 40, 3);
        run_pass(-1, 91, d);
        @(negedge clk);
        checks++;
        if (d !== -1) begin
            errors++;
            $display("FAIL abort_no_done: got done at %0d want none", d);
        end
        checks++;
        if ({pix_valid, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL abort_state: got %b want 000", {pix_valid, busy, done});
        end
        reset = 1'b0;
        ex.delete(); ey.delete(); ec.delete();
        push_rect(40, 40, 3);
        run_pass(-1, -1, d);
        check_stream("after_abort");
        checks++;
        if (d !== 85) begin
            errors++;
            $display("FAIL after_abort_len: got %0d want 85", d);
        end
    endtask

    initial begin
        test_reset();
        test_first_draw();
        test_move();
        test_skip();
        test_clip();
        test_backpressure();
        test_reset_mid_pass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
